sfp_acc_ctrl: RTL and testbench

//  Sequencer for the SFP accumulate+ReLU stage. For each output pixel it

---
 rtl/sfp_pkg.sv | 18 +
 rtl/sfp_addr_gen.sv | 57 +++++
 rtl/sfp_acc_ctrl.sv | 124 ++++++++++++
 tb/tb_sfp_acc_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sfp_pkg.sv
// Shared definitions for the SFP accumulate+ReLU sequencer: state encoding
// and fixed pipeline depths of the surrounding datapath.
package sfp_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // DRAIN covers the final accumulate plus the SFP's ReLU output register.
    localparam int DRAIN_CYC = 2;
    localparam int PMEM_LAT  = 1;

endpackage

// File: rtl/sfp_addr_gen.sv
// Kernel-position (k) and pixel (o) counters plus the running psum address,
// which steps by NUM_OUT per read from base o instead of using a multiplier.
module sfp_addr_gen
    import sfp_pkg::*;
#(
    parameter int NUM_ACC = 9,
    parameter int NUM_OUT = 16,
    parameter int PA_W    = 8,
    parameter int OA_W    = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_clrO,
    input  logic            i_clrK,
    input  logic            i_incK,
    input  logic            i_incO,
    output logic [PA_W-1:0] o_addr,
    output logic [OA_W-1:0] o_o,
    output logic            o_lastK,
    output logic            o_lastO
);

    localparam int KW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

    logic [KW-1:0]   r_k;
    logic [OA_W-1:0] r_o;
    logic [PA_W-1:0] r_addr;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_k    <= '0;
            r_o    <= '0;
            r_addr <= '0;
        end else begin
            if (i_clrO) begin
                r_o <= '0;
            end else if (i_incO) begin
                r_o <= r_o + OA_W'(1);
            end

            // Reloading the base from o at CLEAR realigns the address per pixel.
            if (i_clrK) begin
                r_k    <= '0;
                r_addr <= PA_W'(r_o);
            end else if (i_incK) begin
                r_k    <= r_k + KW'(1);
                r_addr <= r_addr + PA_W'(NUM_OUT);
            end
        end
    end

    assign o_addr  = r_addr;
    assign o_o     = r_o;
    assign o_lastK = (r_k == KW'(NUM_ACC - 1));
    assign o_lastO = (r_o == OA_W'(NUM_OUT - 1));

endmodule

// File: rtl/sfp_acc_ctrl.sv
// Sequencer for the SFP accumulate+ReLU stage: per output pixel it clears the
// accumulators, streams NUM_ACC psum rows into the SFP, drains, then writes.
module sfp_acc_ctrl
    import sfp_pkg::*;
#(
    parameter int NUM_ACC = 9,
    parameter int NUM_OUT = 16,
    parameter int PA_W    = 8,
    parameter int OA_W    = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic            i_stall,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pmem_rd,
    output logic [PA_W-1:0] o_pmem_addr,
    output logic            o_acc_clr,
    output logic            o_acc_en,
    output logic            o_omem_wr,
    output logic [OA_W-1:0] o_omem_addr
);

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    state_t          r_state;
    state_t          w_next;
    logic [DW-1:0]   r_drainCnt;
    logic            w_drainLast;

    logic            w_busy;
    logic            w_done;
    logic            w_issue;
    logic            w_accClr;
    logic            w_omemWr;
    logic            w_clrO;
    logic            w_clrK;
    logic            w_incO;

    logic [PA_W-1:0] w_addr;
    logic [OA_W-1:0] w_o;
    logic            w_lastK;
    logic            w_lastO;

    sfp_addr_gen #(
        .NUM_ACC (NUM_ACC),
        .NUM_OUT (NUM_OUT),
        .PA_W    (PA_W),
        .OA_W    (OA_W)
    ) u_addrGen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clrO  (w_clrO),
        .i_clrK  (w_clrK),
        .i_incK  (w_issue),
        .i_incO  (w_incO),
        .o_addr  (w_addr),
        .o_o     (w_o),
        .o_lastK (w_lastK),
        .o_lastO (w_lastO)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_drainCnt <= '0;
        end else begin
            r_state    <= w_next;
            r_drainCnt <= (r_state == S_DRAIN) ? r_drainCnt + DW'(1) : '0;
        end
    end

    assign w_drainLast = (r_drainCnt == DW'(DRAIN_CYC - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_CLEAR;
            S_CLEAR: w_next = S_READ;
            S_READ:  if (!i_stall && w_lastK) w_next = S_DRAIN;
            S_DRAIN: if (w_drainLast) w_next = S_WRITE;
            S_WRITE: w_next = w_lastO ? S_DONE : S_CLEAR;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // o stops at NUM_OUT-1 on the last write so the counter never wraps in a run.
    always_comb begin
        w_busy   = (r_state != S_IDLE);
        w_done   = (r_state == S_DONE);
        w_issue  = (r_state == S_READ) && !i_stall;
        w_accClr = (r_state == S_CLEAR);
        w_omemWr = (r_state == S_WRITE);
        w_clrO   = (r_state == S_IDLE);
        w_clrK   = (r_state == S_CLEAR);
        w_incO   = (r_state == S_WRITE) && !w_lastO;
    end

    // acc_en follows pmem_rd by the memory latency regardless of state.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pmem_rd   <= 1'b0;
            o_pmem_addr <= '0;
            o_acc_clr   <= 1'b0;
            o_acc_en    <= 1'b0;
            o_omem_wr   <= 1'b0;
            o_omem_addr <= '0;
        end else begin
            o_busy      <= w_busy;
            o_done      <= w_done;
            o_pmem_rd   <= w_issue;
            o_pmem_addr <= w_issue ? w_addr : '0;
            o_acc_clr   <= w_accClr;
            o_acc_en    <= o_pmem_rd;
            o_omem_wr   <= w_omemWr;
            o_omem_addr <= w_omemWr ? w_o : '0;
        end
    end

endmodule

// File: tb/tb_sfp_acc_ctrl.sv
// Bench for sfp_acc_ctrl: builds the expected per-cycle output schedule of
// each run from the pixel/kernel-position ordering and compares every cycle.
module tb_sfp_acc_ctrl;

    localparam int NUM_ACC = 9;
    localparam int NUM_OUT = 16;
    localparam int PA_W    = 8;
    localparam int OA_W    = 4;
    localparam int MAXN    = 1000;

    typedef struct packed {
        logic            busy;
        logic            done;
        logic            rd;
        logic [PA_W-1:0] addr;
        logic            clr;
        logic            en;
        logic            wr;
        logic [OA_W-1:0] waddr;
    } outVec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            stall;
    logic            busy;
    logic            done;
    logic            pmemRd;
    logic [PA_W-1:0] pmemAddr;
    logic            accClr;
    logic            accEn;
    logic            omemWr;
    logic [OA_W-1:0] omemAddr;

    int compared   = 0;
    int mismatched = 0;

    logic    resetPat [MAXN];
    logic    startPat [MAXN];
    logic    stallPat [MAXN];
    outVec_t expVec   [MAXN];

    always #5 clk = ~clk;

    sfp_acc_ctrl #(
        .NUM_ACC (NUM_ACC),
        .NUM_OUT (NUM_OUT),
        .PA_W    (PA_W),
        .OA_W    (OA_W)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_stall     (stall),
        .o_busy      (busy),
        .o_done      (done),
        .o_pmem_rd   (pmemRd),
        .o_pmem_addr (pmemAddr),
        .o_acc_clr   (accClr),
        .o_acc_en    (accEn),
        .o_omem_wr   (omemWr),
        .o_omem_addr (omemAddr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic clearSession();
        for (int n = 0; n < MAXN; n++) begin
            resetPat[n] = (n < 2) ? 1'b0 : 1'b1;
            startPat[n] = 1'b0;
            stallPat[n] = 1'b0;
            expVec[n]   = '0;
        end
    endtask

    task automatic setVec(input int n, input int stopAt, input outVec_t v);
        if (n < stopAt && n < MAXN) expVec[n] = v;
    endtask

    // A run accepted at edge t0 produces, per pixel: clear, NUM_ACC reads in
    // kernel-position order (each delayed by any stalled edge), two drain
    // cycles and one write; the run ends with a single done cycle.
    task automatic buildRun(input int t0, input int stopAt, output int tDone);
        outVec_t v;
        int n;
        n = t0 + 1;
        for (int o = 0; o < NUM_OUT; o++) begin
            v = '0; v.busy = 1'b1; v.clr = 1'b1;
            setVec(n, stopAt, v); n++;
            for (int k = 0; k < NUM_ACC; k++) begin
                while (n < MAXN && stallPat[n]) begin
                    v = '0; v.busy = 1'b1;
                    setVec(n, stopAt, v); n++;
                end
                v = '0; v.busy = 1'b1; v.rd = 1'b1; v.addr = PA_W'(k * NUM_OUT + o);
                setVec(n, stopAt, v); n++;
            end
            for (int d = 0; d < 2; d++) begin
                v = '0; v.busy = 1'b1;
                setVec(n, stopAt, v); n++;
            end
            v = '0; v.busy = 1'b1; v.wr = 1'b1; v.waddr = OA_W'(o);
            setVec(n, stopAt, v); n++;
        end
        v = '0; v.busy = 1'b1; v.done = 1'b1;
        setVec(n, stopAt, v);
        tDone = n;
    endtask

    // acc_en is the previous cycle's read; a reset edge zeroes everything.
    task automatic finalize();
        if (!resetPat[0]) expVec[0] = '0;
        for (int n = 1; n < MAXN; n++) begin
            if (!resetPat[n]) expVec[n] = '0;
            else              expVec[n].en = expVec[n-1].rd;
        end
    endtask

    task automatic applyStimulus(input int len, output int obsDone, output int obsClrAfterDone);
        outVec_t obs;
        int      runLen;
        runLen          = (len < MAXN) ? len : MAXN;
        obsDone         = -1;
        obsClrAfterDone = -1;
        for (int n = 0; n < runLen; n++) begin
            @(negedge clk);
            reset = resetPat[n];
            start = startPat[n];
            stall = stallPat[n];
            @(posedge clk);
            #1;
            obs = '{busy: busy, done: done, rd: pmemRd, addr: pmemAddr,
                    clr: accClr, en: accEn, wr: omemWr, waddr: omemAddr};
            checkOutput($sformatf("cyc%0d", n), 32'(obs), 32'(expVec[n]));
            if (done === 1'b1 && obsDone < 0) obsDone = n;
            if (accClr === 1'b1 && obsDone >= 0 && obsClrAfterDone < 0) obsClrAfterDone = n;
        end
        @(negedge clk);
        start = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        int tA, tB, od, oc;
        reset = 1'b0;
        start = 1'b0;
        stall = 1'b0;

        // Plain run: pixel ordering, full address sequence, done latency.
        clearSession();
        startPat[3] = 1'b1;
        buildRun(3, MAXN, tA);
        finalize();
        applyStimulus(tA + 5, od, oc);
        checkOutput("doneLatencyNoStall", 32'(od - 3), 32'd209);

        // Three stalled edges while pixel 4 is reading.
        clearSession();
        startPat[3] = 1'b1;
        stallPat[60] = 1'b1;
        stallPat[61] = 1'b1;
        stallPat[62] = 1'b1;
        buildRun(3, MAXN, tA);
        finalize();
        applyStimulus(tA + 5, od, oc);
        checkOutput("doneLatencyStall3", 32'(od - 3), 32'd212);

        // Reset mid-run abandons it; a later start gives a clean run.
        clearSession();
        startPat[3]  = 1'b1;
        resetPat[53] = 1'b0;
        resetPat[54] = 1'b0;
        buildRun(3, 53, tA);
        startPat[60] = 1'b1;
        buildRun(60, MAXN, tB);
        finalize();
        applyStimulus(tB + 5, od, oc);
        checkOutput("doneLatencyAfterReset", 32'(od - 60), 32'd209);

        // start while busy is ignored; start held through DONE restarts.
        clearSession();
        startPat[3]  = 1'b1;
        startPat[33] = 1'b1;
        buildRun(3, MAXN, tA);
        for (int n = tA - 5; n <= tA + 1; n++) startPat[n] = 1'b1;
        buildRun(tA + 1, MAXN, tB);
        finalize();
        applyStimulus(tB + 5, od, oc);
        checkOutput("restartClrAfterDone", 32'(oc - od), 32'd2);

        // Random stalls anywhere and stray start pulses while busy.
        clearSession();
        for (int n = 2; n < MAXN; n++) stallPat[n] = ($urandom_range(0, 3) == 0);
        startPat[3] = 1'b1;
        buildRun(3, MAXN, tA);
        for (int n = 4; n <= tA && n < MAXN; n++) startPat[n] = ($urandom_range(0, 15) == 0);
        finalize();
        applyStimulus(tA + 5, od, oc);
        checkOutput("doneRandomStall", 32'(od), 32'(tA));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
